// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
package uart_pkg;
  localparam int DEFAULT_OVERSAMPLE = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       set_break;
  } lcr_t;
  function automatic int tick_width(input int os);
    return $clog2(os * 2);
  endfunction
  function automatic logic [7:0] word_mask(input logic [1:0] wls);
    return 8'hFF >> (2'd3 - wls);
  endfunction
  function automatic int stop_ticks(input logic stb, input logic [1:0] wls, input int os);
    return !stb ? os : (wls == 2'd0 ? os * 3 / 2 : os * 2);
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART16550 transmit shifter, FIFO pop to serial tx.
// Define UART_TX_BREAK_EN to let set_break force tx low.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       pop,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       set_break,
  output logic       tx,
  output logic       tsr_empty
);
  localparam int TW = tick_width(OVERSAMPLE);
  tx_state_e state, state_n;
  lcr_t lcr;
  logic [TW-1:0] tick_cnt, last_tick;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par, load, tick_end, last_bit, fsm_tx, unused_lcr;
  assign last_tick = TW'(state == STOP ? stop_ticks(lcr.stb, lcr.wls, OVERSAMPLE) - 1 : OVERSAMPLE - 1);
  assign tick_end  = baud_pulse && tick_cnt == last_tick;
  assign last_bit  = bit_cnt == {1'b0, lcr.wls} + 3'd4;
  // A new frame starts from IDLE or straight out of the final stop tick.
  assign load = !rst && !fifo_empty && baud_pulse && (state == IDLE || (state == STOP && tick_end));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb
    state_n = load             ? START :
              !tick_end        ? state :
              state == START   ? DATA :
              state == DATA    ? (last_bit ? (lcr.pen ? PARITY : STOP) : DATA) :
              state == PARITY  ? STOP : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      lcr      <= '0;
      par      <= 1'b0;
    end else if (load) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= fifo_dout;
      lcr      <= '{wls: wls, stb: stb, pen: pen, eps: eps, sp: sp, set_break: set_break};
      par      <= ^(fifo_dout & word_mask(wls));
    end else if (baud_pulse && state != IDLE) begin
      tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
      if (tick_end && state == DATA) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  always_comb begin
    fsm_tx = state == START  ? 1'b0 :
             state == DATA   ? shreg[0] :
             state == PARITY ? (lcr.sp ? ~lcr.eps : (lcr.eps ? par : ~par)) : 1'b1;
`ifdef UART_TX_BREAK_EN
    tx = fsm_tx & ~set_break;
`else
    tx = fsm_tx;
`endif
    pop       = load;
    tsr_empty = state == IDLE;
  end
`ifdef UART_TX_BREAK_EN
  assign unused_lcr = lcr.set_break;
`else
  assign unused_lcr = ^{lcr.set_break, set_break};
`endif
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench; frames are predicted per baud tick from LCR and data.
module tb_uart_tx_serializer;
  localparam int OS = 16;
  logic clk = 1'b0, rst = 1'b1, baud_pulse = 1'b0, fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic [1:0] wls = 2'd0;
  logic stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, set_break = 1'b0;
  logic pop, tx, tsr_empty;
  int tests = 0, fails = 0;
  logic [7:0] fifo_q[$];
  bit exp_ticks[$];
  int exp_len[$];
  bit mon_en = 0, stall = 0, pop_q = 0, idle_chk = 0, brk = 0, e = 0, got = 0, want = 0;
  int remaining = 0, bad = 0, first_bad = 0, idx = 0, frame_no = 0;

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .pop(pop), .wls(wls), .stb(stb), .pen(pen), .eps(eps),
    .sp(sp), .set_break(set_break), .tx(tx), .tsr_empty(tsr_empty)
  );

  initial forever #5 clk = ~clk;

  task automatic fifo_upd();
    fifo_empty = fifo_q.size() == 0;
    fifo_dout  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // FIFO pop and random baud ticks, applied just after the clock edge
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_q) begin
      void'(fifo_q.pop_front());
      fifo_upd();
    end
    baud_pulse = !stall && ($urandom_range(0, 1) == 1);
  end

  // Reference model: a frame is a list of per-tick line levels
  task automatic push_byte(input logic [7:0] d);
    int n, ones, st;
    bit p;
    n = 5 + int'(wls);
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    p  = sp ? !eps : (eps ? (ones % 2 == 1) : (ones % 2 == 0));
    st = !stb ? OS : (wls == 2'd0 ? OS * 3 / 2 : OS * 2);
    repeat (OS) exp_ticks.push_back(1'b0);
    for (int i = 0; i < n; i++) repeat (OS) exp_ticks.push_back(d[i]);
    if (pen) repeat (OS) exp_ticks.push_back(p);
    repeat (st) exp_ticks.push_back(1'b1);
    exp_len.push_back(OS * (1 + n + int'(pen)) + st);
    fifo_q.push_back(d);
    fifo_upd();
  endtask

  task automatic set_lcr(input logic [1:0] w, input logic s, input logic p, input logic ev,
                         input logic k, input logic b);
    @(posedge clk);
    #2;
    wls = w; stb = s; pen = p; eps = ev; sp = k; set_break = b;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((fifo_q.size() != 0 || remaining != 0 || tsr_empty !== 1'b1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    tests++;
    if (t >= 20000) begin
      fails++;
      $display("FAIL drain_timeout: fifo=%0d remaining=%0d tsr_empty=%b, required all drained", fifo_q.size(), remaining, tsr_empty);
    end
  endtask

  task automatic wait_fifo_empty();
    int t;
    t = 0;
    while (fifo_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      tests++;
      fails++;
      $display("FAIL fifo_timeout: fifo=%0d, required 0", fifo_q.size());
    end
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    pop_q = pop;
    if (mon_en) begin
      brk = 0;
`ifdef UART_TX_BREAK_EN
      brk = set_break;
`endif
      if (idle_chk) begin
        tests++;
        if (tsr_empty !== 1'b1 || tx !== !brk) begin
          fails++;
          $display("FAIL idle_after_frame %0d: tsr_empty=%b tx=%b, required tsr_empty=1 tx=%b", frame_no, tsr_empty, tx, !brk);
        end
        idle_chk = 0;
      end
      if (baud_pulse && remaining > 0) begin
        e = exp_ticks.pop_front() & !brk;
        if (tx !== e || tsr_empty !== 1'b0) begin
          if (bad == 0) begin
            first_bad = idx; got = tx; want = e;
          end
          bad++;
        end
        idx++;
        remaining--;
        if (remaining == 0) begin
          tests++;
          if (bad != 0) begin
            fails++;
            $display("FAIL frame %0d: %0d bad ticks, first at tick %0d tx=%b required %b", frame_no, bad, first_bad, got, want);
          end
          tests++;
          if (pop !== 1'(fifo_q.size() > 0)) begin
            fails++;
            $display("FAIL back_to_back frame %0d: pop=%b required %b", frame_no, pop, fifo_q.size() > 0);
          end
          idle_chk = fifo_q.size() == 0;
          frame_no++;
        end
      end
      if (pop) begin
        tests++;
        if (fifo_q.size() == 0 || remaining != 0 || exp_len.size() == 0) begin
          fails++;
          $display("FAIL pop: fifo=%0d remaining=%0d, required pop only on idle/stop end with data", fifo_q.size(), remaining);
        end else begin
          remaining = exp_len.pop_front();
          bad = 0;
          idx = 0;
        end
      end
    end
  end

  initial begin
    int t, n;
    logic hold;
    fifo_upd();
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || pop !== 1'b0 || tsr_empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: tx=%b pop=%b tsr_empty=%b, required 1 0 1", tx, pop, tsr_empty);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    // Abort a frame mid-DATA with reset
    wls = 2'd3;
    fifo_q.push_back(8'hC2);
    fifo_upd();
    t = 0;
    do begin @(negedge clk); t++; end while (!pop && t < 1000);
    n = 0;
    while (n < 20 && t < 5000) begin
      @(negedge clk);
      t++;
      if (baud_pulse) n++;
    end
    tests++;
    if (tx !== 1'b0 || tsr_empty !== 1'b0) begin
      fails++;
      $display("FAIL mid_data: tx=%b tsr_empty=%b, required 0 0", tx, tsr_empty);
    end
    fifo_q.push_back(8'hFF);
    fifo_upd();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (tx !== 1'b1 || pop !== 1'b0 || tsr_empty !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: tx=%b pop=%b tsr_empty=%b, required 1 0 1", tx, pop, tsr_empty);
    end
    repeat (6) begin
      @(negedge clk);
      tests++;
      if (pop !== 1'b0) begin
        fails++;
        $display("FAIL pop_in_reset: pop=%b, required 0", pop);
      end
    end
    fifo_q.delete();
    fifo_upd();
    @(posedge clk);
    #2 rst = 1'b0;
    mon_en = 1;
    // Directed frames
    set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); push_byte(8'hA5); wait_idle();
    set_lcr(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); push_byte(8'h41); wait_idle();
    set_lcr(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); push_byte(8'h1F); wait_idle();
    set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_byte(8'h55); push_byte(8'hAA); wait_idle();
    // Stalled baud_pulse freezes the line
    set_lcr(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); push_byte(8'h96);
    t = 0;
    while (remaining == 0 && t < 1000) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    stall = 1;
    repeat (2) @(negedge clk);
    hold = tx;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== hold || tsr_empty !== 1'b0) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL stall_hold: %0d cycles changed, required tx=%b held", n, hold);
    end
    stall = 0;
    wait_idle();
    // Random traffic; LCR and break change while the last frame is still on the line
    repeat (40) begin
      wait_fifo_empty();
      repeat ($urandom_range(0, 300)) @(negedge clk);
      set_lcr(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 7) == 0);
      n = $urandom_range(1, 3);
      repeat (n) push_byte(8'($urandom));
    end
    wait_idle();
    set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
